// File: rtl/signal_head_driver_pkg.sv
// ---------------------------------------------------------------------------
// traffic_pkg
//   Shared encodings for the traffic-signal head driver: the 4-bit state
//   codes produced by the traffic FSM, lamp drive patterns {red,amber,green},
//   the driver's internal modes and small decode helpers.
// ---------------------------------------------------------------------------
package traffic_pkg;

  // State codes from the traffic FSM; anything with code[3:2] != 0 is invalid.
  localparam logic [3:0] S_NS_GREEN = 4'd0;
  localparam logic [3:0] S_NS_AMBER = 4'd1;
  localparam logic [3:0] S_EW_GREEN = 4'd2;
  localparam logic [3:0] S_EW_AMBER = 4'd3;

  // Lamp drives, bit order {red, amber, green}.
  localparam logic [2:0] LAMP_RED   = 3'b100;
  localparam logic [2:0] LAMP_AMBER = 3'b010;
  localparam logic [2:0] LAMP_GREEN = 3'b001;
  localparam logic [2:0] LAMP_OFF   = 3'b000;

  typedef enum logic [1:0] {
    M_CLEAR = 2'd0,
    M_RUN   = 2'd1,
    M_FAULT = 2'd2
  } mode_t;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_NS   = 2'd1,
    DIR_EW   = 2'd2
  } dir_t;

  typedef struct packed {
    logic [2:0] ns;
    logic [2:0] ew;
  } lamp_pair_t;

  function automatic logic is_valid_code(input logic [3:0] code);
    return (code == S_NS_GREEN) || (code == S_NS_AMBER) ||
           (code == S_EW_GREEN) || (code == S_EW_AMBER);
  endfunction

  function automatic dir_t dir_of(input logic [3:0] code);
    return ((code == S_EW_GREEN) || (code == S_EW_AMBER)) ? DIR_EW : DIR_NS;
  endfunction

  // Run-mode lamp pattern for a valid code; invalid codes decode to all-red.
  function automatic lamp_pair_t decode_lamps(input logic [3:0] code);
    lamp_pair_t r;
    r.ns = LAMP_RED;
    r.ew = LAMP_RED;
    case (code)
      S_NS_GREEN: r.ns = LAMP_GREEN;
      S_NS_AMBER: r.ns = LAMP_AMBER;
      S_EW_GREEN: r.ew = LAMP_GREEN;
      S_EW_AMBER: r.ew = LAMP_AMBER;
      default: ;
    endcase
    return r;
  endfunction

  function automatic logic is_onehot3(input logic [2:0] lamp);
    return (lamp == LAMP_RED) || (lamp == LAMP_AMBER) || (lamp == LAMP_GREEN);
  endfunction

endpackage

// File: rtl/signal_head_driver_lamp_flasher.sv
// ---------------------------------------------------------------------------
// lamp_flasher
//   Half-period divider for the fail-safe flashing amber. While 'clear' is
//   high the divider is held at the start of an "on" half-period, so the
//   first cycle after clear drops is the second cycle of that "on" phase.
//   The output is the phase the divider will hold after the coming edge,
//   letting the parent register it straight into its lamp outputs.
//
// Ports:
//   clk      in   system clock
//   reset    in   synchronous reset, active-low
//   clear    in   hold divider at the start of an "on" phase
//   flash_on out  next-cycle flash phase (1 = lamps on)
// ---------------------------------------------------------------------------
module lamp_flasher
  import traffic_pkg::*;
#(
  parameter int FLASH_HALF = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic flash_on
);

  localparam int CW = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
  localparam logic [CW-1:0] LAST = CW'(FLASH_HALF - 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          phase;
  logic          phase_next;

  always_comb begin
    cnt_next   = cnt;
    phase_next = phase;
    if (clear) begin
      cnt_next   = '0;
      phase_next = 1'b1;
    end else if (cnt == LAST) begin
      cnt_next   = '0;
      phase_next = ~phase;
    end else begin
      cnt_next   = cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt   <= '0;
      phase <= 1'b1;
    end else begin
      cnt   <= cnt_next;
      phase <= phase_next;
    end
  end

  assign flash_on = phase_next;

endmodule

// File: rtl/signal_head_driver.sv
// ---------------------------------------------------------------------------
// signal_head_driver
//   Converts the traffic FSM's state code into registered lamp drives for
//   the north-south and east-west signal heads. Any change of right-of-way
//   direction is routed through an all-red clearance of ALLRED_CYCLES.
//   Persistent invalid codes or an unsafe lamp pattern latch a flashing-amber
//   fail-safe that only reset can leave.
//
// Ports:
//   clk       in   system clock
//   reset     in   synchronous reset, active-low
//   state_in  in   [3:0] FSM currentState code
//   ns_lamp   out  [2:0] north-south {red,amber,green}, registered
//   ew_lamp   out  [2:0] east-west {red,amber,green}, registered
//   clearing  out  all-red clearance in progress
//   fault     out  sticky fail-safe indicator
// ---------------------------------------------------------------------------
module signal_head_driver
  import traffic_pkg::*;
#(
  parameter int ALLRED_CYCLES = 2,
  parameter int FLASH_HALF    = 4,
  parameter int INVALID_LIMIT = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] state_in,
  output logic [2:0] ns_lamp,
  output logic [2:0] ew_lamp,
  output logic       clearing,
  output logic       fault
);

  localparam int CLR_W = $clog2(ALLRED_CYCLES + 1);
  localparam int INV_W = $clog2(INVALID_LIMIT + 1);

  // Reset loads the full count because the first edge after reset release is
  // itself the first clearance cycle; a direction change loads one less since
  // the entry edge already shows all-red with clearing high.
  localparam logic [CLR_W-1:0] CLR_FULL  = CLR_W'(ALLRED_CYCLES);
  localparam logic [CLR_W-1:0] CLR_ENTRY = CLR_W'(ALLRED_CYCLES - 1);
  localparam logic [INV_W-1:0] INV_MAX   = INV_W'(INVALID_LIMIT);

  mode_t            mode;
  dir_t             dir;
  logic [CLR_W-1:0] clr_cnt;
  logic [INV_W-1:0] inv_cnt;
  logic [INV_W-1:0] inv_next;
  logic [3:0]       tgt_code;
  logic             tgt_valid;

  logic             code_valid;
  dir_t             code_dir;
  lamp_pair_t       run_lamps;
  logic [3:0]       exit_code;
  lamp_pair_t       exit_lamps;
  logic             conflict;
  logic             fault_trip;
  logic             flash_clear;
  logic             flash_on;
  logic [2:0]       flash_lamp;

  assign code_valid = is_valid_code(state_in);
  assign code_dir   = dir_of(state_in);
  assign run_lamps  = decode_lamps(state_in);

  // Leaving clearance shows the freshest valid code, including this cycle's.
  assign exit_code  = code_valid ? state_in : tgt_code;
  assign exit_lamps = decode_lamps(exit_code);

  // Checked on the registered outputs, so a bad pattern trips on the next edge.
  assign conflict = (ns_lamp[0] & ew_lamp[0]) |
                    ~is_onehot3(ns_lamp) | ~is_onehot3(ew_lamp);

  // Both trip sources look at registered state, so FAULT outranks any
  // direction change decided on the same edge.
  assign fault_trip = (mode != M_FAULT) && ((inv_cnt == INV_MAX) || conflict);

  // Saturating count of consecutive invalid codes.
  always_comb begin
    inv_next = inv_cnt;
    if (code_valid) begin
      inv_next = '0;
    end else if (inv_cnt != INV_MAX) begin
      inv_next = inv_cnt + INV_W'(1);
    end
  end

  // Held cleared outside FAULT so the flash always opens with amber on.
  assign flash_clear = (mode != M_FAULT);
  assign flash_lamp  = flash_on ? LAMP_AMBER : LAMP_OFF;

  lamp_flasher #(
    .FLASH_HALF (FLASH_HALF)
  ) u_flasher (
    .clk      (clk),
    .reset    (reset),
    .clear    (flash_clear),
    .flash_on (flash_on)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      mode      <= M_CLEAR;
      dir       <= DIR_NONE;
      clr_cnt   <= CLR_FULL;
      inv_cnt   <= '0;
      tgt_code  <= S_NS_GREEN;
      tgt_valid <= 1'b0;
      ns_lamp   <= LAMP_RED;
      ew_lamp   <= LAMP_RED;
      clearing  <= 1'b0;
      fault     <= 1'b0;
    end else begin
      case (mode)
        M_FAULT: begin
          ns_lamp  <= flash_lamp;
          ew_lamp  <= flash_lamp;
          clearing <= 1'b0;
          fault    <= 1'b1;
        end

        default: begin
          inv_cnt <= inv_next;

          if (fault_trip) begin
            mode     <= M_FAULT;
            ns_lamp  <= flash_lamp;
            ew_lamp  <= flash_lamp;
            clearing <= 1'b0;
            fault    <= 1'b1;
          end else if (mode == M_RUN) begin
            // Invalid codes fall through and hold the current lamps.
            if (code_valid) begin
              if (code_dir == dir) begin
                ns_lamp <= run_lamps.ns;
                ew_lamp <= run_lamps.ew;
              end else begin
                mode      <= M_CLEAR;
                clr_cnt   <= CLR_ENTRY;
                tgt_code  <= state_in;
                tgt_valid <= 1'b1;
                ns_lamp   <= LAMP_RED;
                ew_lamp   <= LAMP_RED;
                clearing  <= 1'b1;
              end
            end
          end else begin
            // Clearance: track the latest valid target without restarting.
            if (code_valid) begin
              tgt_code  <= state_in;
              tgt_valid <= 1'b1;
            end

            if (clr_cnt != '0) begin
              clr_cnt  <= clr_cnt - CLR_W'(1);
              ns_lamp  <= LAMP_RED;
              ew_lamp  <= LAMP_RED;
              clearing <= 1'b1;
            end else if (code_valid || tgt_valid) begin
              mode     <= M_RUN;
              dir      <= dir_of(exit_code);
              ns_lamp  <= exit_lamps.ns;
              ew_lamp  <= exit_lamps.ew;
              clearing <= 1'b0;
            end else begin
              ns_lamp  <= LAMP_RED;
              ew_lamp  <= LAMP_RED;
              clearing <= 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_signal_head_driver.sv
// ---------------------------------------------------------------------------
// tb_signal_head_driver
//   Directed-vector bench for signal_head_driver with default parameters
//   (ALLRED_CYCLES=2, FLASH_HALF=4, INVALID_LIMIT=3). Inputs change 1 ns after
//   each rising edge and outputs are sampled at that same point.
// ---------------------------------------------------------------------------
module tb_signal_head_driver;

  logic       clk;
  logic       reset;
  logic [3:0] state_in;
  logic [2:0] ns_lamp;
  logic [2:0] ew_lamp;
  logic       clearing;
  logic       fault;

  int checks   = 0;
  int failures = 0;

  signal_head_driver #(
    .ALLRED_CYCLES (2),
    .FLASH_HALF    (4),
    .INVALID_LIMIT (3)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .state_in (state_in),
    .ns_lamp  (ns_lamp),
    .ew_lamp  (ew_lamp),
    .clearing (clearing),
    .fault    (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0] exp_flash;

    // Reset held with a valid code present.
    reset    = 1'b0;
    state_in = 4'd0;
    tick();
    tick();
    check("rst_ns", {1'b0, ns_lamp}, 4'b0100);
    check("rst_ew", {1'b0, ew_lamp}, 4'b0100);
    check("rst_clearing", {3'b0, clearing}, 4'd0);
    check("rst_fault", {3'b0, fault}, 4'd0);

    // Release: two cycles of all-red clearance, then NS green.
    reset = 1'b1;
    tick();
    check("pr_clr1", {3'b0, clearing}, 4'd1);
    check("pr_ns_red1", {1'b0, ns_lamp}, 4'b0100);
    tick();
    check("pr_clr2", {3'b0, clearing}, 4'd1);
    check("pr_ew_red2", {1'b0, ew_lamp}, 4'b0100);
    tick();
    check("pr_ns_green", {1'b0, ns_lamp}, 4'b0001);
    check("pr_ew_red", {1'b0, ew_lamp}, 4'b0100);
    check("pr_clr_done", {3'b0, clearing}, 4'd0);

    // Same-direction change: one-cycle latency, no clearance.
    state_in = 4'd1;
    tick();
    check("same_ns_amber", {1'b0, ns_lamp}, 4'b0010);
    check("same_ew_red", {1'b0, ew_lamp}, 4'b0100);
    check("same_no_clr", {3'b0, clearing}, 4'd0);

    // Direction change NS -> EW: exactly two clearing cycles.
    state_in = 4'd2;
    tick();
    check("dc_ns_red", {1'b0, ns_lamp}, 4'b0100);
    check("dc_ew_red", {1'b0, ew_lamp}, 4'b0100);
    check("dc_clr1", {3'b0, clearing}, 4'd1);
    tick();
    check("dc_clr2", {3'b0, clearing}, 4'd1);
    tick();
    check("dc_ew_green", {1'b0, ew_lamp}, 4'b0001);
    check("dc_ns_red_after", {1'b0, ns_lamp}, 4'b0100);
    check("dc_clr_done", {3'b0, clearing}, 4'd0);

    // Two invalid cycles below the limit: lamps hold, no fault.
    state_in = 4'hF;
    tick();
    tick();
    check("inv2_ew_hold", {1'b0, ew_lamp}, 4'b0001);
    check("inv2_no_fault", {3'b0, fault}, 4'd0);
    state_in = 4'd2;
    tick();
    check("inv2_recover_ew", {1'b0, ew_lamp}, 4'b0001);
    check("inv2_recover_fault", {3'b0, fault}, 4'd0);

    // Three invalid cycles reach the limit; the following edge enters FAULT
    // even though a valid opposite-direction code arrives on that edge.
    state_in = 4'hF;
    tick();
    tick();
    tick();
    check("inv3_pre_fault", {3'b0, fault}, 4'd0);
    check("inv3_ew_hold", {1'b0, ew_lamp}, 4'b0001);
    state_in = 4'd0;
    tick();
    check("flt_fault", {3'b0, fault}, 4'd1);
    check("flt_ns_amber", {1'b0, ns_lamp}, 4'b0010);
    check("flt_ew_amber", {1'b0, ew_lamp}, 4'b0010);
    check("flt_no_clr", {3'b0, clearing}, 4'd0);

    // Flashing continues with valid codes applied; fault stays latched.
    for (int k = 1; k < 12; k++) begin
      state_in = 4'(k % 4);
      tick();
      exp_flash = (((k / 4) % 2) == 0) ? 3'b010 : 3'b000;
      check($sformatf("flash_ns_%0d", k), {1'b0, ns_lamp}, {1'b0, exp_flash});
      check($sformatf("flash_ew_%0d", k), {1'b0, ew_lamp}, {1'b0, exp_flash});
      check($sformatf("flash_fault_%0d", k), {3'b0, fault}, 4'd1);
    end

    // Reset leaves FAULT.
    reset = 1'b0;
    tick();
    check("frst_fault", {3'b0, fault}, 4'd0);
    check("frst_ns", {1'b0, ns_lamp}, 4'b0100);
    check("frst_clr", {3'b0, clearing}, 4'd0);
    reset    = 1'b1;
    state_in = 4'd0;
    tick();
    tick();
    tick();
    check("frst_ns_green", {1'b0, ns_lamp}, 4'b0001);

    // Target updated during clearance; the countdown is not restarted.
    state_in = 4'd2;
    tick();
    check("tgt_clr1", {3'b0, clearing}, 4'd1);
    state_in = 4'd3;
    tick();
    check("tgt_clr2", {3'b0, clearing}, 4'd1);
    check("tgt_ew_red", {1'b0, ew_lamp}, 4'b0100);
    tick();
    check("tgt_ew_amber", {1'b0, ew_lamp}, 4'b0010);
    check("tgt_ns_red", {1'b0, ns_lamp}, 4'b0100);
    check("tgt_clr_done", {3'b0, clearing}, 4'd0);

    // Reset pulse mid-clearance restarts a full clearance.
    state_in = 4'd0;
    tick();
    check("mrst_clr_in", {3'b0, clearing}, 4'd1);
    reset = 1'b0;
    tick();
    check("mrst_clr_low", {3'b0, clearing}, 4'd0);
    check("mrst_ew_red", {1'b0, ew_lamp}, 4'b0100);
    reset = 1'b1;
    tick();
    check("mrst_clr1", {3'b0, clearing}, 4'd1);
    tick();
    check("mrst_clr2", {3'b0, clearing}, 4'd1);
    tick();
    check("mrst_ns_green", {1'b0, ns_lamp}, 4'b0001);
    check("mrst_clr_done", {3'b0, clearing}, 4'd0);

    // Move to EW green, then force a double-green conflict.
    state_in = 4'd2;
    tick();
    tick();
    tick();
    check("cf_ew_green", {1'b0, ew_lamp}, 4'b0001);
    check("cf_pre_fault", {3'b0, fault}, 4'd0);
    force dut.ns_lamp = 3'b001;
    tick();
    check("cf_fault", {3'b0, fault}, 4'd1);
    check("cf_ew_amber", {1'b0, ew_lamp}, 4'b0010);
    release dut.ns_lamp;
    tick();
    check("cf_ns_amber", {1'b0, ns_lamp}, 4'b0010);
    check("cf_fault_hold", {3'b0, fault}, 4'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/signal_head_driver.md
Name: signal_head_driver

Overview:
- Downstream consumer of the traffic FSM's 4-bit currentState.
- Decodes the state code into per-approach lamp drives for north-south and east-west signal heads.
- Inserts a guaranteed all-red clearance whenever right-of-way changes direction.
- Enters a sticky flashing-amber fail-safe on persistent invalid codes or a lamp conflict.

Parameters:
ALLRED_CYCLES, 2, all-red clearance length in clk cycles (>=1)
FLASH_HALF, 4, fault flash half-period in clk cycles (>=1)
INVALID_LIMIT, 3, consecutive invalid-code cycles that trigger fault (>=1)

Ports:
clk  input  1  system clock
reset  input  1  synchronous reset, active-low (asserted when 0)
state_in  input  4  FSM currentState code
ns_lamp  output  3  north-south lamps {red,amber,green}, registered
ew_lamp  output  3  east-west lamps {red,amber,green}, registered
clearing  output  1  high while all-red clearance is active
fault  output  1  sticky fail-safe indicator

Behaviour:
- State codes:
  - 0 = NS_GREEN
  - 1 = NS_AMBER
  - 2 = EW_GREEN
  - 3 = EW_AMBER
  - 4..15 are invalid.
- Direction: codes 0 and 1 are NS; codes 2 and 3 are EW.
- Run-mode lamps:
  - NS_GREEN: ns=001, ew=100
  - NS_AMBER: ns=010, ew=100
  - EW_GREEN: ns=100, ew=001
  - EW_AMBER: ns=100, ew=010
- Internal modes: CLEAR, RUN, FAULT. All outputs are registered.
- Reset (reset==0 at a clk edge):
  - ns_lamp=100, ew_lamp=100, clearing=0, fault=0.
  - Mode becomes CLEAR with clr_cnt=ALLRED_CYCLES. Displayed direction = none. Invalid counter = 0.
  - Reset overrides every mode, including FAULT and mid-clearance.
- CLEAR mode:
  - Lamps stay 100/100; clearing=1 from the first edge after reset deasserts, or from the edge of entry.
  - A valid state_in sampled during CLEAR updates the target code; the clr_cnt countdown is not restarted.
  - Exit: all-red is visible for exactly ALLRED_CYCLES cycles. On the following edge the lamps show the latest valid target, clearing=0, and mode becomes RUN.
  - If no valid target has been seen, stay in CLEAR with all-red.
- RUN mode:
  - Valid code, same direction as displayed: lamps update on the next edge (1-cycle latency).
  - Valid code, different direction: on the next edge lamps go 100/100, clearing=1, mode CLEAR, target = code.
  - Invalid code: lamps hold their previous value.
- Invalid counter:
  - Increments on each cycle state_in is invalid, in RUN or CLEAR; any valid code zeroes it.
  - When it reaches INVALID_LIMIT, the next edge enters FAULT.
  - Invalid codes never change the CLEAR target.
- Conflict check (RUN/CLEAR): if registered ns_lamp and ew_lamp both have green set, or either lamp is not one-hot, enter FAULT on the next edge.
- FAULT mode:
  - fault=1, clearing=0.
  - On entry ns=ew=010, then both toggle between 010 and 000 every FLASH_HALF cycles.
  - state_in is ignored; FAULT exits only on reset.
- Simultaneous invalid-limit and direction change: FAULT takes priority.

Decomposition:
- Package traffic_pkg:
  - 4-bit state code constants (S_NS_GREEN, S_NS_AMBER, S_EW_GREEN, S_EW_AMBER).
  - Lamp encodings (LAMP_RED=100, LAMP_AMBER=010, LAMP_GREEN=001, LAMP_OFF=000).
  - Mode encoding.
- Sub-module lamp_flasher:
  - FLASH_HALF-cycle divider producing flash phase; synchronous clear on FAULT entry so the phase starts "on".
- Clearance and invalid counters stay inline.

Test Plan:
- Hold reset=0 with state_in=0, then release: lamps 100/100 and clearing=1 for 2 cycles, then ns=001, ew=100, clearing=0.
- In RUN at code 0, change to 1: ns=010 on the next edge, clearing never asserts.
- In RUN at code 1, change to 2: next edge 100/100 with clearing=1 for exactly 2 cycles, then ew=001, ns=100.
- state_in=4'hF for 2 cycles, then 0: no fault, lamps hold. state_in=4'hF for 3 cycles: fault=1, both lamps 010 for 4 cycles, 000 for 4 cycles, repeating. Then drive valid codes: fault stays 1 until reset.
- During CLEAR (target 2), change state_in to 3 after 1 cycle: clearance still ends at the original time and shows ew=010. Pulse reset=0 mid-clearance: next edge 100/100, clearing=0, then a fresh 2-cycle clearance.
- Force ns_lamp and ew_lamp green simultaneously via hierarchical force in RUN: fault=1 on the next edge with flashing amber.
